// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard controller.
package hazard_pkg;

  localparam int MEM_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } hz_state_e;

  // Pipeline control action chosen each cycle, in priority order.
  typedef enum logic [2:0] {
    ACT_NORMAL  = 3'd0,
    ACT_RESET   = 3'd1,
    ACT_ERROR   = 3'd2,
    ACT_FREEZE  = 3'd3,
    ACT_BRANCH  = 3'd4,
    ACT_LOADUSE = 3'd5
  } hz_action_e;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module hazard_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stalls, branch flushes, memory freeze with timeout.
// Performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       Rs1_ID,
  input  logic [4:0]       Rs2_ID,
  input  logic [4:0]       Rd_EX,
  input  logic             MemRead_EX,
  input  logic             Branch_taken_EX,
  input  logic             MemReq_MEM,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             ID_EX_Write,
  output logic             EX_MEM_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             MEM_WB_Bubble,
  output logic             MemError,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);

  hz_state_e   state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic        lu_q, lu_d;
  hz_action_e  act;
  logic        memstall, loaduse, freeze, timeout;

  assign memstall = MemReq_MEM && !MemReady;
  assign loaduse  = MemRead_EX && (Rd_EX != 5'd0) &&
                    ((Rd_EX == Rs1_ID) || (Rd_EX == Rs2_ID));

  // Once waiting, the access stays outstanding until MemReady.
  assign freeze  = (state_q == MEM_WAIT) ? !MemReady : memstall;
  // The entry cycle in RUN is the first frozen cycle, so the error fires on
  // the MEM_TIMEOUT-th consecutive frozen cycle (wait count reaching MEM_TIMEOUT-1).
  assign timeout = (state_q == MEM_WAIT) && !MemReady &&
                   (wait_q == WAIT_W'(MEM_TIMEOUT - 2));

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      wait_q  <= '0;
      lu_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      lu_q    <= lu_d;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        if (memstall) begin
          state_d = MEM_WAIT;
          wait_d  = '0;
        end
      end
      MEM_WAIT: begin
        if (MemReady) begin
          state_d = RUN;
        end else if (timeout) begin
          state_d = ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ERROR:   state_d = ERROR;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    if (RST)                        act = ACT_RESET;
    else if (state_q == ERROR)      act = ACT_ERROR;
    else if (freeze)                act = ACT_FREEZE;
    else if (Branch_taken_EX)       act = ACT_BRANCH;
    else if (loaduse && !lu_q)      act = ACT_LOADUSE;
    else                            act = ACT_NORMAL;

    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Flush   = 1'b0;
    MEM_WB_Bubble = 1'b0;
    MemError      = 1'b0;

    case (act)
      ACT_RESET, ACT_ERROR: begin
        PCWrite       = 1'b0;
        IF_ID_Write   = 1'b0;
        ID_EX_Write   = 1'b0;
        EX_MEM_Write  = 1'b0;
        IF_ID_Flush   = 1'b1;
        ID_EX_Flush   = 1'b1;
        MEM_WB_Bubble = 1'b1;
        MemError      = (act == ACT_ERROR);
      end
      ACT_FREEZE: begin
        PCWrite       = 1'b0;
        IF_ID_Write   = 1'b0;
        ID_EX_Write   = 1'b0;
        EX_MEM_Write  = 1'b0;
        MEM_WB_Bubble = 1'b1;
      end
      ACT_BRANCH: begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end
      ACT_LOADUSE: begin
        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
      end
      default: ;
    endcase
  end

  // After a load-use bubble EX holds that bubble, so the repeated match is stale.
  assign lu_d = (act == ACT_LOADUSE);

`ifdef HAZARD_PERF_CNT_EN
  logic stall_evt, flush_evt;

  assign stall_evt = !PCWrite && !RST;
  assign flush_evt = (act == ACT_BRANCH);

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (CLK),
    .clr_i (RST),
    .en_i  (stall_evt),
    .cnt_o (StallCycles)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (CLK),
    .clr_i (RST),
    .en_i  (flush_evt),
    .cnt_o (FlushCount)
  );
`else
  assign StallCycles = '0;
  assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller (MEM_TIMEOUT=4, CNT_W=4); counter expectations follow HAZARD_PERF_CNT_EN.
module tb_hazard_controller;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int CW = 4;

  // {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, IF_ID_Flush, ID_EX_Flush, MEM_WB_Bubble, MemError}
  localparam logic [7:0] O_NORM  = 8'b1111_0000;
  localparam logic [7:0] O_FRZ   = 8'b0000_0010;
  localparam logic [7:0] O_BR    = 8'b1111_1100;
  localparam logic [7:0] O_LU    = 8'b0011_0100;
  localparam logic [7:0] O_RST   = 8'b0000_1110;
  localparam logic [7:0] O_ERR   = 8'b0000_1111;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       mq;
    logic       rdy;
  } in_t;

  typedef struct {
    string      name;
    in_t        in;
    logic [7:0] exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    rs1, rs2, rd;
  logic          mem_read, br_taken, mem_req, mem_ready;
  logic          pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, bubble, mem_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [7:0]    outs;

  int n_cmp  = 0;
  int n_fail = 0;

  hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .CLK             (clk),
    .RST             (rst),
    .Rs1_ID          (rs1),
    .Rs2_ID          (rs2),
    .Rd_EX           (rd),
    .MemRead_EX      (mem_read),
    .Branch_taken_EX (br_taken),
    .MemReq_MEM      (mem_req),
    .MemReady        (mem_ready),
    .PCWrite         (pc_w),
    .IF_ID_Write     (ifid_w),
    .ID_EX_Write     (idex_w),
    .EX_MEM_Write    (exmem_w),
    .IF_ID_Flush     (ifid_f),
    .ID_EX_Flush     (idex_f),
    .MEM_WB_Bubble   (bubble),
    .MemError        (mem_err),
    .StallCycles     (stall_cnt),
    .FlushCount      (flush_cnt)
  );

  always #5 clk = ~clk;

  assign outs = {pc_w, ifid_w, idex_w, exmem_w, ifid_f, idex_f, bubble, mem_err};

  function automatic in_t mk(int a, int b, int d, bit mr, bit br, bit mq, bit rdy);
    in_t v;
    v.rs1 = 5'(a);
    v.rs2 = 5'(b);
    v.rd  = 5'(d);
    v.mr  = mr;
    v.br  = br;
    v.mq  = mq;
    v.rdy = rdy;
    return v;
  endfunction

  function automatic logic [31:0] cnt_exp(int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t v);
    rs1       = v.rs1;
    rs2       = v.rs2;
    rd        = v.rd;
    mem_read  = v.mr;
    br_taken  = v.br;
    mem_req   = v.mq;
    mem_ready = v.rdy;
  endtask

  // Apply inputs for one cycle, compare outputs mid-cycle, then advance past the edge.
  task automatic cyc(input string name, input in_t v, input logic [7:0] exp);
    apply(v);
    @(negedge clk);
    check(name, 32'(outs), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(mk(0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t vecs[14];
  in_t  z, lu5, stall, stall_br;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    z        = mk(0, 0, 0, 0, 0, 0, 0);
    lu5      = mk(1, 5, 5, 1, 0, 0, 0);
    stall    = mk(0, 0, 0, 0, 0, 1, 0);
    stall_br = mk(0, 0, 0, 0, 1, 1, 0);

    vecs[0]  = '{"idle",              z,                          O_NORM};
    vecs[1]  = '{"lu_rs2",            lu5,                        O_LU};
    vecs[2]  = '{"lu_rs1",            mk(5, 2, 5, 1, 0, 0, 0),    O_LU};
    vecs[3]  = '{"lu_rd0",            mk(0, 0, 0, 1, 0, 0, 0),    O_NORM};
    vecs[4]  = '{"match_no_load",     mk(5, 0, 5, 0, 0, 0, 0),    O_NORM};
    vecs[5]  = '{"load_no_match",     mk(3, 4, 7, 1, 0, 0, 0),    O_NORM};
    vecs[6]  = '{"branch",            mk(0, 0, 0, 0, 1, 0, 0),    O_BR};
    vecs[7]  = '{"branch_over_lu",    mk(1, 5, 5, 1, 1, 0, 0),    O_BR};
    vecs[8]  = '{"memstall",          stall,                      O_FRZ};
    vecs[9]  = '{"memstall_over_br",  stall_br,                   O_FRZ};
    vecs[10] = '{"memstall_over_lu",  mk(1, 5, 5, 1, 0, 1, 0),    O_FRZ};
    vecs[11] = '{"mem_ready",         mk(0, 0, 0, 0, 0, 1, 1),    O_NORM};
    vecs[12] = '{"ready_lu",          mk(9, 5, 5, 1, 0, 1, 1),    O_LU};
    vecs[13] = '{"lu_r31",            mk(31, 0, 31, 1, 0, 0, 0),  O_LU};

    // Reset state while RST is held.
    rst = 1'b1;
    apply(lu5);
    @(posedge clk);
    @(negedge clk);
    check("reset_outs", 32'(outs), 32'(O_RST));
    check("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    check("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-cycle decode from a fresh RUN state.
    for (int i = 0; i < 14; i++) begin
      do_reset();
      cyc(vecs[i].name, vecs[i].in, vecs[i].exp);
    end

    // Load-use with inputs held: exactly one bubble.
    do_reset();
    cyc("lu_hold_c1", lu5, O_LU);
    cyc("lu_hold_c2", lu5, O_NORM);
    cyc("lu_after", z, O_NORM);
    check("lu_stall_cnt", 32'(stall_cnt), cnt_exp(1));

    // Branch wins over load-use and is counted.
    do_reset();
    cyc("br_lu", mk(5, 1, 5, 1, 1, 0, 0), O_BR);
    cyc("br_after", z, O_NORM);
    check("br_flush_cnt", 32'(flush_cnt), cnt_exp(1));
    check("br_stall_cnt", 32'(stall_cnt), cnt_exp(0));

    // Three frozen cycles with a pending branch, released by MemReady.
    do_reset();
    for (int i = 0; i < 3; i++) cyc($sformatf("wait_frz%0d", i), stall_br, O_FRZ);
    cyc("wait_release_br", mk(0, 0, 0, 0, 1, 1, 1), O_BR);
    cyc("wait_run", z, O_NORM);
    check("wait_stall_cnt", 32'(stall_cnt), cnt_exp(3));
    check("wait_flush_cnt", 32'(flush_cnt), cnt_exp(1));

    // Timeout: four frozen cycles, then sticky ERROR until RST.
    do_reset();
    for (int i = 0; i < 4; i++) cyc($sformatf("to_frz%0d", i), stall, O_FRZ);
    cyc("to_error", stall, O_ERR);
    cyc("err_sticky_idle", z, O_ERR);
    cyc("err_sticky_ready", mk(0, 0, 0, 0, 1, 1, 1), O_ERR);
    rst = 1'b1;
    cyc("err_rst", z, O_RST);
    rst = 1'b0;
    cyc("err_cleared", z, O_NORM);
    check("err_cleared_cnt", 32'(stall_cnt), 32'd0);

    // RST in the middle of MEM_WAIT aborts the wait.
    do_reset();
    cyc("abort_frz0", stall, O_FRZ);
    cyc("abort_frz1", stall, O_FRZ);
    rst = 1'b1;
    cyc("abort_rst", stall, O_RST);
    rst = 1'b0;
    cyc("abort_run", z, O_NORM);

    // Long stall drives StallCycles into saturation.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      apply(stall);
      @(posedge clk);
      #1;
    end
    apply(stall);
    @(negedge clk);
    check("sat_mid", 32'(stall_cnt), cnt_exp(14));
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("sat_hold", 32'(stall_cnt), cnt_exp(15));
    check("sat_flush", 32'(flush_cnt), 32'd0);
    check("sat_err", 32'(outs), 32'(O_ERR));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 SHALL have parameter: MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before error (≥2).
REQ-002 SHALL have parameter: CNT_W, 32, width of performance counters.
REQ-003 SHALL have ports:
- CLK  in  1  clock, all state on rising edge.
- RST  in  1  reset; one clock; reset is synchronous and active-high.
- Rs1_ID, Rs2_ID  in  5 each  source registers of the instruction in ID.
- Rd_EX  in  5  destination of the instruction in EX.
- MemRead_EX  in  1  EX instruction is a load.
- Branch_taken_EX  in  1  taken branch/jump resolved in EX.
- MemReq_MEM  in  1  MEM instruction accesses data memory.
- MemReady  in  1  data memory completes the access this cycle.
- PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write  out  1 each  stage register enables.
- IF_ID_Flush, ID_EX_Flush  out  1 each  insert bubble into that stage register.
- MEM_WB_Bubble  out  1  write a bubble into MEM/WB.
- MemError  out  1  sticky memory-timeout flag.
- StallCycles, FlushCount  out  CNT_W each  performance counters.

Function
REQ-004 SHALL implement FSM states RUN, MEM_WAIT, ERROR; all outputs combinational from state and current inputs.
REQ-005 SHALL define memstall = MemReq_MEM && !MemReady, loaduse = MemRead_EX && Rd_EX!=0 && (Rd_EX==Rs1_ID || Rd_EX==Rs2_ID).
REQ-006 SHALL apply priority: ERROR > memstall > Branch_taken_EX > loaduse > normal.
REQ-007 Normal: all four write enables 1, flushes 0, MEM_WB_Bubble 0.
REQ-008 memstall (RUN or MEM_WAIT): all four write enables 0, MEM_WB_Bubble 1, flushes 0.
REQ-009 Branch flush: enables 1, IF_ID_Flush=1, ID_EX_Flush=1, same cycle; loaduse ignored (ID is wrong-path).
REQ-010 Loaduse: PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, ID_EX_Write=1, EX_MEM_Write=1; exactly one bubble per load.
REQ-011 RUN→MEM_WAIT when memstall; MEM_WAIT→RUN on the cycle MemReady=1 (freeze released that same cycle).
REQ-012 Wait counter SHALL clear on entering MEM_WAIT, increment each MEM_WAIT cycle with MemReady=0; at MEM_TIMEOUT-1 with MemReady=0 → ERROR.
REQ-013 ERROR: all write enables 0, both flushes 1, MEM_WB_Bubble 1, MemError 1; left only by RST.
REQ-014 Branch_taken_EX during memstall SHALL be held off; flush occurs in the first unfrozen cycle (branch still in EX).

Reset
REQ-015 While RST=1: state←RUN, wait counter 0, MemError 0, counters 0; outputs forced PCWrite..EX_MEM_Write=0, IF_ID_Flush=ID_EX_Flush=1, MEM_WB_Bubble=1.
REQ-016 RST mid-MEM_WAIT or in ERROR SHALL abort immediately; normal outputs from first cycle after RST deasserts.

Configuration
REQ-017 Macro HAZARD_PERF_CNT_EN defined: StallCycles counts cycles with PCWrite=0 (RST excluded), FlushCount counts branch-flush cycles; both saturate at all-ones.
REQ-018 Macro undefined: ports remain, tied to 0, no counter logic synthesized.

Structure
REQ-019 Package hazard_pkg SHALL hold the FSM state enum and the default MEM_TIMEOUT constant.
REQ-020 Sub-module hazard_sat_counter (CNT_W, enable, clear, saturating) SHALL implement both performance counters.

Verification
REQ-021 Rd_EX=5, MemRead_EX=1, Rs2_ID=5 → one cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1; next cycle normal.
REQ-022 Rd_EX=0, MemRead_EX=1, Rs1_ID=0 → no stall.
REQ-023 Branch_taken_EX=1 with loaduse true → IF_ID_Flush=ID_EX_Flush=1, PCWrite=1; FlushCount +1.
REQ-024 MemReq_MEM=1, MemReady low 3 cycles then high → 3 frozen cycles, 4th cycle enables 1, state RUN; StallCycles=3.
REQ-025 MEM_TIMEOUT=4, MemReady held 0 → ERROR after 4 frozen cycles, MemError=1 held until RST; RST clears it.
REQ-026 Counters preset near all-ones via long stall → StallCycles saturates, no wrap.
